// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - handshake bundle between the UART register block and the transmitter
//
// Signals:
//   uart_tx_en     transmit enable; gates acceptance of new frames only
//   uart_tx_data   word to send (PAYLOAD_BITS wide)
//   uart_tx_valid  uart_tx_data is valid
//   uart_tx_ready  word accepted in any cycle where valid && ready
//   uart_tx_break  request a BREAK frame
//   uart_tx_busy   a frame or break is in progress
// Modports: master = register-block side, slave = transmitter side.

interface uart_tx_if #(
    parameter int PAYLOAD_BITS = 8
);
    logic                    uart_tx_en;
    logic [PAYLOAD_BITS-1:0] uart_tx_data;
    logic                    uart_tx_valid;
    logic                    uart_tx_ready;
    logic                    uart_tx_break;
    logic                    uart_tx_busy;

    modport master (
        output uart_tx_en,
        output uart_tx_data,
        output uart_tx_valid,
        output uart_tx_break,
        input  uart_tx_ready,
        input  uart_tx_busy
    );

    modport slave (
        input  uart_tx_en,
        input  uart_tx_data,
        input  uart_tx_valid,
        input  uart_tx_break,
        output uart_tx_ready,
        output uart_tx_busy
    );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start bit, LSB-first data, stop bits, BREAK generation
//
// Ports:
//   clk             system clock
//   reset           synchronous, active-high reset
//   cycles_per_bit  bit period minus one, in clk cycles (shared with the receiver)
//   tx              uart_tx_if.slave handshake (en, data, valid, ready, break, busy)
//   uart_txd        registered serial line, idle high

module uart_tx #(
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cycles_per_bit,
    uart_tx_if.slave    tx,
    output logic        uart_txd
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    localparam logic [3:0] LAST_DATA  = 4'(PAYLOAD_BITS - 1);
    localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);
    localparam logic [3:0] LAST_BREAK = 4'(PAYLOAD_BITS + 1);

    state_t                  state;
    logic [31:0]             cycle_counter;
    logic [31:0]             cpb_l;
    logic [3:0]              bit_counter;
    logic [PAYLOAD_BITS-1:0] shift_reg;

    logic bit_done;
    logic last_stop_cycle;
    logic accept;
    logic take_break;

    assign bit_done        = (cycle_counter == cpb_l);
    assign last_stop_cycle = (state == STOP) && (bit_counter == LAST_STOP) && bit_done;

    // Ready also opens in the final stop cycle so a waiting word starts with no idle gap.
    assign tx.uart_tx_ready = tx.uart_tx_en && !tx.uart_tx_break &&
                              ((state == IDLE) || last_stop_cycle);
    assign accept           = tx.uart_tx_valid && tx.uart_tx_ready;
    assign take_break       = (state == IDLE) && tx.uart_tx_en && tx.uart_tx_break;
    assign tx.uart_tx_busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cycle_counter <= '0;
            cpb_l         <= '0;
            bit_counter   <= '0;
            shift_reg     <= '0;
            uart_txd      <= 1'b1;
        end else if (accept) begin
            // Bit timing is frozen for the whole frame at acceptance.
            state         <= START;
            shift_reg     <= tx.uart_tx_data;
            cpb_l         <= cycles_per_bit;
            cycle_counter <= '0;
            bit_counter   <= '0;
            uart_txd      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    uart_txd <= 1'b1;
                    if (take_break) begin
                        state         <= BREAK;
                        cpb_l         <= cycles_per_bit;
                        cycle_counter <= '0;
                        bit_counter   <= '0;
                        uart_txd      <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state         <= DATA;
                        cycle_counter <= '0;
                        bit_counter   <= '0;
                        uart_txd      <= shift_reg[0];
                    end else begin
                        cycle_counter <= cycle_counter + 32'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cycle_counter <= '0;
                        shift_reg     <= shift_reg >> 1;
                        if (bit_counter == LAST_DATA) begin
                            state       <= STOP;
                            bit_counter <= '0;
                            uart_txd    <= 1'b1;
                        end else begin
                            bit_counter <= bit_counter + 4'd1;
                            // Output the bit that the shift is bringing into position 0.
                            uart_txd    <= shift_reg[1];
                        end
                    end else begin
                        cycle_counter <= cycle_counter + 32'd1;
                    end
                end
                STOP: begin
                    uart_txd <= 1'b1;
                    if (bit_done) begin
                        cycle_counter <= '0;
                        if (bit_counter == LAST_STOP) begin
                            state       <= IDLE;
                            bit_counter <= '0;
                        end else begin
                            bit_counter <= bit_counter + 4'd1;
                        end
                    end else begin
                        cycle_counter <= cycle_counter + 32'd1;
                    end
                end
                BREAK: begin
                    // Line held low for a start bit, the data bits and one extra bit period.
                    if (bit_done) begin
                        cycle_counter <= '0;
                        if (bit_counter == LAST_BREAK) begin
                            state       <= STOP;
                            bit_counter <= '0;
                            uart_txd    <= 1'b1;
                        end else begin
                            bit_counter <= bit_counter + 4'd1;
                        end
                    end else begin
                        cycle_counter <= cycle_counter + 32'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    uart_txd <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: serialises one PAYLOAD_BITS word per frame onto uart_txd (start bit, data LSB first, STOP_BITS stop bits).
- Bit timing comes from the same runtime cycles_per_bit register value that drives the receiver, so both ends of a link share one baud setting.
- Sits between the CPU-side UART register block and the TX pin.
- Valid/ready handshake with back-to-back frames at full line rate; can also generate a BREAK.

Parameters:
PAYLOAD_BITS, 8, data bits per frame (5..9).
STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
cycles_per_bit  input  32  bit period minus one, in clk cycles.
uart_tx_en  input  1  transmit enable; gates acceptance of new frames only.
uart_tx_data  input  PAYLOAD_BITS  word to send.
uart_tx_valid  input  1  uart_tx_data is valid.
uart_tx_ready  output  1  frame accepted this cycle when valid && ready.
uart_tx_break  input  1  request a BREAK frame.
uart_tx_busy  output  1  frame in progress.
uart_txd  output  1  serial line, registered, idle high.

Behaviour:
- Reset: uart_txd=1, uart_tx_busy=0, state IDLE, counters 0. uart_tx_ready follows its equation below once reset is released. Reset mid-frame aborts the frame; uart_txd is 1 on the next edge.
- Bit period = cycles_per_bit+1 clocks, counted with cycle_counter 0..cpb_l. cpb_l is cycles_per_bit latched at frame acceptance, so changes mid-frame have no effect. cycles_per_bit=0 gives 1 clock per bit. Counter compare is full 32-bit.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: uart_txd=1, busy=0.
  - uart_tx_break && uart_tx_en -> BREAK. Break has priority over valid in the same cycle; the data word is not consumed.
  - Else valid && ready -> START. Latch data into the shift register and latch cpb_l.
- START: uart_txd=0 for one bit period -> DATA.
- DATA: uart_txd = shift_reg[0]. At the end of each bit period, shift right and increment bit_counter (4 bits). After PAYLOAD_BITS bits -> STOP.
- STOP: uart_txd=1 for STOP_BITS bit periods -> IDLE.
- BREAK: uart_txd=0 for PAYLOAD_BITS+2 bit periods, then -> STOP (normal stop bits).
- uart_tx_ready = uart_tx_en && !uart_tx_break && (state==IDLE || (state==STOP && last stop bit && cycle_counter==cpb_l)).
  - Acceptance in the final STOP cycle goes directly to START with no idle gap.
  - Back-to-back frame period = (1+PAYLOAD_BITS+STOP_BITS)*(cycles_per_bit+1) clocks exactly.
- uart_txd is registered: it changes on the clock edge where the state/bit changes. The first 0 appears on the edge that accepts the frame.
- busy = (state != IDLE).
- uart_tx_en low: an ongoing frame or break completes normally; no new acceptance.
- uart_tx_data/valid are ignored when ready=0. Valid may be held high; each accepting cycle consumes exactly one word.

Test Plan:
- cycles_per_bit=3, send 0xA5 once -> uart_txd, 4 clocks per bit: 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop). busy high for exactly 40 clocks; ready high again in the 40th cycle.
- cycles_per_bit=3, valid held high with 0x00 then 0xFF -> no idle gap; second start bit begins at clock 40 after the first acceptance; total 80 clocks.
- Loopback uart_txd into uart_rx (cycles_per_bit=433, STOP_BITS=2), send 0x00,0x55,0xFF,0x3C -> receiver reports the same four bytes, rx_break never set.
- Assert uart_tx_break with valid also high, cycles_per_bit=1 -> txd low for 20 clocks, then high 2 clocks; data not consumed (ready low throughout). Looped-back receiver flags break.
- Change cycles_per_bit from 3 to 7 mid-frame -> current frame keeps 4-clock bits; next frame uses 8-clock bits.
- Assert reset during DATA bit 3 -> next edge txd=1, busy=0, ready=1 (en high). A subsequent 0x81 frame is transmitted correctly.
